ev21g1_prefetch_queue: RTL and testbench
========================================

Name: ev21g1_prefetch_queue

Overview:
Instruction prefetch stage for the ev21g1 core. It sits between the synchronous program memory and the decode stage.
- Generates sequential fetch addresses and issues reads with 1-cycle memory latency.
- Buffers returned words with their PCs in a small FIFO and hands them to decode over valid/ready.
- Flushes and restarts on a branch/jump redirect.

Parameters:
ADDR_WIDTH, 10, program-memory word address width; PC wraps modulo 2^ADDR_WIDTH
DATA_WIDTH, 32, instruction word width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
imem_rd  out  1  read strobe to program memory
imem_addr  out  ADDR_WIDTH  fetch address, sampled by memory on rising edge when imem_rd=1
imem_data  in  DATA_WIDTH  read data, valid throughout the cycle after the sampling edge
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  new fetch address
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts head
instr  out  DATA_WIDTH  head instruction word; 0 when instr_valid=0
instr_pc  out  ADDR_WIDTH  head word address; 0 when instr_valid=0
level  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
State:
- fetch_pc: next address to issue.
- inflight: 1 if a read was issued at the previous edge.
- squash: marks an in-flight response to discard.
- FIFO: DEPTH entries of {word, pc} with rd/wr pointers and count.

Reset (async, takes effect immediately, held while reset=1):
- fetch_pc=RESET_PC, count=0, inflight=0, squash=0.
- Outputs: imem_rd=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, level=0.

Issue:
- imem_rd = !reset && !redirect && (count + inflight < DEPTH).
- imem_addr = fetch_pc.
- On an edge with imem_rd=1: fetch_pc <= fetch_pc+1 (wraps), inflight <= 1, and the pc tag is recorded.
- Otherwise inflight <= 0.

Fill:
- At the edge ending a cycle with inflight=1 and squash=0, push {imem_data, tag}.
- The credit rule guarantees no overflow.

Drain:
- Pop when instr_valid && instr_ready.
- Push and pop on the same edge is legal, including when full or empty, and count is unchanged.

Timing:
- Latency address-issue to instr_valid is 2 edges.
- Throughput is 1 word/cycle with instr_ready held high.
- After a full queue drains, refill shows no bubble.

Redirect (sampled at edge E0):
- count <= 0 (queue flushed) and fetch_pc <= redirect_pc.
- Any pop in the same cycle is void; the word is dropped and does not count.
- An in-flight response captured at E0 is discarded.
- imem_rd=0 in the redirect cycle; first read of redirect_pc is issued in the next cycle.
- instr_valid rises after E2.
- A redirect held for consecutive cycles restarts each cycle; the last redirect_pc wins.

Wrap: PC sequence 2^ADDR_WIDTH-1 -> 0 with no gap.

Optional Feature:
Macro EV21G1_PREFETCH_FLUSH_CNT_EN.
- Defined: adds output port flush_count (16 bits), counting accepted redirect edges.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
  - Not affected by instr_ready.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
Defaults DEPTH=4, ADDR_WIDTH=10, RESET_PC=0, memory model imem[a]=32'hA000_0000+a, 1-cycle latency.
1. Release reset, instr_ready=1 -> imem_addr 0,1,2,... each cycle; instr_valid high after 2nd edge; instr/instr_pc = A0000000/0, A0000001/1, ... one per cycle, no gaps.
2. instr_ready=0 from reset -> level reaches 4, imem_rd=0, imem_addr=4; then set instr_ready=1 -> 8 consecutive words A0000000..A0000007 with no bubble.
3. Queue holding 3 entries plus a read in flight, redirect=1, redirect_pc=0x100 -> level=0 next cycle; next valid word is A0000100/pc 0x100; no stale word appears.
4. redirect=1 with instr_valid=instr_ready=1 in the same cycle -> head word dropped, level=0; next word is from redirect_pc.
5. redirect_pc=0x3FE -> instr_pc sequence 0x3FE, 0x3FF, 0x000, 0x001; instr A00003FE, A00003FF, A0000000.
6. Assert reset mid-stream between edges -> instr_valid=0, level=0, imem_rd=0 immediately; after release, refetch starts at 0; with EV21G1_PREFETCH_FLUSH_CNT_EN, flush_count=0 after reset and 2 after two redirects.

Source files
------------

// File: rtl/ev21g1_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// ev21g1_prefetch_queue_if
// Bundles the prefetch stage's program-memory read port, the redirect
// request from the branch unit and the valid/ready handshake to decode.
//
// Signals:
//   imem_rd, imem_addr   read strobe / word address to program memory
//   imem_data            read data, valid the cycle after the sampling edge
//   redirect, redirect_pc flush-and-restart request with target address
//   instr_valid/ready    head-of-queue handshake with decode
//   instr, instr_pc      head word and its address (0 when not valid)
//   level                current queue occupancy
//
// Modports:
//   master  the prefetch queue itself
//   slave   the environment (memory, branch unit, decode)
// ---------------------------------------------------------------------------
interface ev21g1_prefetch_queue_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                  imem_rd;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_data;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic [LW-1:0]         level;

   modport master (
      output imem_rd, imem_addr,
      input  imem_data,
      input  redirect, redirect_pc,
      output instr_valid,
      input  instr_ready,
      output instr, instr_pc, level
   );

   modport slave (
      input  imem_rd, imem_addr,
      output imem_data,
      output redirect, redirect_pc,
      input  instr_valid,
      output instr_ready,
      input  instr, instr_pc, level
   );
endinterface

// File: rtl/ev21g1_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ev21g1_prefetch_queue
// Instruction prefetch stage between the synchronous program memory
// (1-cycle read latency) and decode. Issues sequential fetch addresses,
// buffers returned words with their PCs in a DEPTH-entry FIFO and hands
// them to decode over valid/ready. A redirect flushes the queue, drops
// any in-flight response and restarts fetch at redirect_pc.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   bus          ev21g1_prefetch_queue_if.master (memory, redirect, decode)
//   flush_count  16-bit saturating count of redirect edges (optional)
//
// Build option:
//   EV21G1_PREFETCH_FLUSH_CNT_EN  adds the flush_count output and counter.
// ---------------------------------------------------------------------------
module ev21g1_prefetch_queue #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int RESET_PC   = 0
) (
   input  logic clk,
   input  logic reset,
   ev21g1_prefetch_queue_if.master bus
`ifdef EV21G1_PREFETCH_FLUSH_CNT_EN
   ,
   output logic [15:0] flush_count
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] word;
      logic [ADDR_WIDTH-1:0] pc;
   } entry_t;

   entry_t                fifo [DEPTH];
   logic [PW-1:0]         rd_ptr, wr_ptr;
   logic [CW-1:0]         count;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] tag;        // address of the read currently in flight
   logic                  inflight;
   logic                  squash;
   logic                  issue, push, pop;
   logic [CW:0]           credit;

   // NOTE: always_comb assigns every output before any condition, so no
   // latch can be inferred even if a branch is later added.
   always_comb begin
      credit = {1'b0, count} + {{CW{1'b0}}, inflight};
      squash = bus.redirect;
      // Reserve a slot for every outstanding read so a response always fits.
      issue  = !reset && !bus.redirect && (credit < DEPTH_C);
      // A response landing on a redirect edge belongs to the old stream.
      push   = inflight && !squash;
      // A pop coinciding with a redirect is void: the word is flushed instead.
      pop    = (count != '0) && bus.instr_ready && !bus.redirect;
   end

   assign bus.imem_rd     = issue;
   assign bus.imem_addr   = fetch_pc;
   assign bus.instr_valid = (count != '0);
   assign bus.instr       = (count != '0) ? fifo[rd_ptr].word : '0;
   assign bus.instr_pc    = (count != '0) ? fifo[rd_ptr].pc   : '0;
   assign bus.level       = count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= ADDR_WIDTH'(RESET_PC);
         tag      <= '0;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            fetch_pc <= fetch_pc + 1'b1;   // wraps modulo 2^ADDR_WIDTH
            tag      <= fetch_pc;
         end
         if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // NOTE: the storage array has no reset; count gates every read of it,
   // so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= '{word: bus.imem_data, pc: tag};
   end

`ifdef EV21G1_PREFETCH_FLUSH_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         flush_count <= '0;
      else if (bus.redirect && (flush_count != 16'hFFFF))
         flush_count <= flush_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ev21g1_prefetch_queue.sv
module tb_ev21g1_prefetch_queue;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ev21g1_prefetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

`ifdef EV21G1_PREFETCH_FLUSH_CNT_EN
   logic [15:0] flush_count;
`endif

   ev21g1_prefetch_queue #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef EV21G1_PREFETCH_FLUSH_CNT_EN
      ,
      .flush_count (flush_count)
`endif
   );

   // Synchronous program memory, 1-cycle latency: imem[a] = A000_0000 + a.
   always @(posedge clk)
      if (bus.imem_rd) bus.imem_data <= 32'hA000_0000 + 32'(bus.imem_addr);

   typedef struct {
      logic        rst;
      logic        redir;
      logic [9:0]  rpc;
      logic        rdy;
      logic        e_rd;
      logic [9:0]  e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [9:0]  e_pc;
      logic [2:0]  e_lvl;
      logic [15:0] e_fc;
   } vec_t;

   vec_t vecs[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic row(input logic rst, input logic redir, input logic [9:0] rpc, input logic rdy,
                      input logic rd, input logic [9:0] addr, input logic valid,
                      input logic [31:0] instr, input logic [9:0] pc, input logic [2:0] lvl,
                      input logic [15:0] fc);
      vec_t v;
      v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
      v.e_rd = rd; v.e_addr = addr; v.e_valid = valid; v.e_instr = instr;
      v.e_pc = pc; v.e_lvl = lvl; v.e_fc = fc;
      vecs.push_back(v);
   endtask

   initial begin
      int wait_cycles;
      logic [9:0] epc;

      // Each row: inputs for one cycle, outputs expected in that cycle.
      // rst redir rpc   rdy | rd addr  valid instr          pc     lvl fc
      // Stream from reset with decode ready, then redirect with a pop pending.
      row(0, 0, 10'h000, 1,  1, 10'h000, 0, 32'h0,          10'h000, 0, 0);
      row(0, 0, 10'h000, 1,  1, 10'h001, 0, 32'h0,          10'h000, 0, 0);
      row(0, 0, 10'h000, 1,  1, 10'h002, 1, 32'hA000_0000,  10'h000, 1, 0);
      row(0, 0, 10'h000, 1,  1, 10'h003, 1, 32'hA000_0001,  10'h001, 1, 0);
      row(0, 0, 10'h000, 1,  1, 10'h004, 1, 32'hA000_0002,  10'h002, 1, 0);
      row(0, 0, 10'h000, 1,  1, 10'h005, 1, 32'hA000_0003,  10'h003, 1, 0);
      row(0, 1, 10'h3FE, 1,  0, 10'h006, 1, 32'hA000_0004,  10'h004, 1, 0);
      row(0, 0, 10'h000, 1,  1, 10'h3FE, 0, 32'h0,          10'h000, 0, 1);
      row(0, 0, 10'h000, 1,  1, 10'h3FF, 0, 32'h0,          10'h000, 0, 1);
      row(0, 0, 10'h000, 1,  1, 10'h000, 1, 32'hA000_03FE,  10'h3FE, 1, 1);
      row(0, 0, 10'h000, 1,  1, 10'h001, 1, 32'hA000_03FF,  10'h3FF, 1, 1);
      row(0, 0, 10'h000, 1,  1, 10'h002, 1, 32'hA000_0000,  10'h000, 1, 1);
      row(0, 0, 10'h000, 1,  1, 10'h003, 1, 32'hA000_0001,  10'h001, 1, 1);
      // Reset, then fill with decode stalled, then drain with no bubble.
      row(1, 0, 10'h000, 0,  0, 10'h000, 0, 32'h0,          10'h000, 0, 0);
      row(0, 0, 10'h000, 0,  1, 10'h000, 0, 32'h0,          10'h000, 0, 0);
      row(0, 0, 10'h000, 0,  1, 10'h001, 0, 32'h0,          10'h000, 0, 0);
      row(0, 0, 10'h000, 0,  1, 10'h002, 1, 32'hA000_0000,  10'h000, 1, 0);
      row(0, 0, 10'h000, 0,  1, 10'h003, 1, 32'hA000_0000,  10'h000, 2, 0);
      row(0, 0, 10'h000, 0,  0, 10'h004, 1, 32'hA000_0000,  10'h000, 3, 0);
      row(0, 0, 10'h000, 0,  0, 10'h004, 1, 32'hA000_0000,  10'h000, 4, 0);
      row(0, 0, 10'h000, 1,  0, 10'h004, 1, 32'hA000_0000,  10'h000, 4, 0);
      row(0, 0, 10'h000, 1,  1, 10'h004, 1, 32'hA000_0001,  10'h001, 3, 0);
      row(0, 0, 10'h000, 1,  1, 10'h005, 1, 32'hA000_0002,  10'h002, 2, 0);
      row(0, 0, 10'h000, 1,  1, 10'h006, 1, 32'hA000_0003,  10'h003, 2, 0);
      row(0, 0, 10'h000, 1,  1, 10'h007, 1, 32'hA000_0004,  10'h004, 2, 0);
      row(0, 0, 10'h000, 1,  1, 10'h008, 1, 32'hA000_0005,  10'h005, 2, 0);
      row(0, 0, 10'h000, 1,  1, 10'h009, 1, 32'hA000_0006,  10'h006, 2, 0);
      row(0, 0, 10'h000, 1,  1, 10'h00A, 1, 32'hA000_0007,  10'h007, 2, 0);
      // Three entries plus a read in flight, then redirect to 0x100.
      row(0, 0, 10'h000, 0,  1, 10'h00B, 1, 32'hA000_0008,  10'h008, 2, 0);
      row(0, 1, 10'h100, 0,  0, 10'h00C, 1, 32'hA000_0008,  10'h008, 3, 0);
      row(0, 0, 10'h000, 1,  1, 10'h100, 0, 32'h0,          10'h000, 0, 1);
      row(0, 0, 10'h000, 1,  1, 10'h101, 0, 32'h0,          10'h000, 0, 1);
      row(0, 0, 10'h000, 1,  1, 10'h102, 1, 32'hA000_0100,  10'h100, 1, 1);
      row(0, 0, 10'h000, 1,  1, 10'h103, 1, 32'hA000_0101,  10'h101, 1, 1);
      // Reset mid-stream between edges, held for two cycles, then refetch.
      row(1, 0, 10'h000, 1,  0, 10'h000, 0, 32'h0,          10'h000, 0, 0);
      row(1, 0, 10'h000, 1,  0, 10'h000, 0, 32'h0,          10'h000, 0, 0);
      row(0, 0, 10'h000, 1,  1, 10'h000, 0, 32'h0,          10'h000, 0, 0);
      row(0, 0, 10'h000, 1,  1, 10'h001, 0, 32'h0,          10'h000, 0, 0);
      row(0, 0, 10'h000, 1,  1, 10'h002, 1, 32'hA000_0000,  10'h000, 1, 0);
      // Redirect held two cycles: the second target wins.
      row(0, 1, 10'h200, 1,  0, 10'h003, 1, 32'hA000_0001,  10'h001, 1, 0);
      row(0, 1, 10'h050, 1,  0, 10'h200, 0, 32'h0,          10'h000, 0, 1);
      row(0, 0, 10'h000, 1,  1, 10'h050, 0, 32'h0,          10'h000, 0, 2);
      row(0, 0, 10'h000, 1,  1, 10'h051, 0, 32'h0,          10'h000, 0, 2);
      row(0, 0, 10'h000, 1,  1, 10'h052, 1, 32'hA000_0050,  10'h050, 1, 2);

      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.instr_ready = 1'b0;
      reset           = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         reset           = vecs[i].rst;
         bus.redirect    = vecs[i].redir;
         bus.redirect_pc = vecs[i].rpc;
         bus.instr_ready = vecs[i].rdy;
         #1;
         check($sformatf("row%0d imem_rd", i),     32'(bus.imem_rd),     32'(vecs[i].e_rd));
         check($sformatf("row%0d imem_addr", i),   32'(bus.imem_addr),   32'(vecs[i].e_addr));
         check($sformatf("row%0d instr_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_valid));
         check($sformatf("row%0d instr", i),       bus.instr,            vecs[i].e_instr);
         check($sformatf("row%0d instr_pc", i),    32'(bus.instr_pc),    32'(vecs[i].e_pc));
         check($sformatf("row%0d level", i),       32'(bus.level),       32'(vecs[i].e_lvl));
`ifdef EV21G1_PREFETCH_FLUSH_CNT_EN
         check($sformatf("row%0d flush_count", i), 32'(flush_count),     32'(vecs[i].e_fc));
`endif
         @(negedge clk);
      end

      // Redirect near the top of the address space, bounded wait for the
      // first word, then eight back-to-back words across the wrap.
      bus.redirect    = 1'b1;
      bus.redirect_pc = 10'h3FC;
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.redirect    = 1'b0;
      wait_cycles = 0;
      #1;
      while (!bus.instr_valid && wait_cycles < 10) begin
         @(negedge clk);
         #1;
         wait_cycles++;
      end
      check("wrap first-word latency", 32'(wait_cycles), 32'd2);
      for (int i = 0; i < 8; i++) begin
         epc = 10'h3FC + 10'(i);
         check($sformatf("wrap%0d instr_valid", i), 32'(bus.instr_valid), 32'd1);
         check($sformatf("wrap%0d instr_pc", i),    32'(bus.instr_pc),    32'(epc));
         check($sformatf("wrap%0d instr", i),       bus.instr,            32'hA000_0000 | 32'(epc));
         @(negedge clk);
         #1;
      end
`ifdef EV21G1_PREFETCH_FLUSH_CNT_EN
      check("flush_count after wrap redirect", 32'(flush_count), 32'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
